// File: rtl/hour_setter_12to24.sv
// Hour register for the clock: advances on minute carry while running and is
// edited with buttons in 12h or 24h view while set_en is held.
module hour_setter_12to24 #(
    parameter int HW = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mode,
    input  logic          set_en,
    input  logic          btn_inc,
    input  logic          btn_dec,
    input  logic          btn_ampm,
    input  logic          carry_in,
    output logic [HW-1:0] hour24,
    output logic [HW-1:0] disp_hour,
    output logic          pm,
    output logic          day_carry,
    output logic          setting
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    localparam logic [HW-1:0] H0  = HW'(0);
    localparam logic [HW-1:0] H1  = HW'(1);
    localparam logic [HW-1:0] H11 = HW'(11);
    localparam logic [HW-1:0] H12 = HW'(12);
    localparam logic [HW-1:0] H23 = HW'(23);

    localparam int B_INC  = 0;
    localparam int B_DEC  = 1;
    localparam int B_AMPM = 2;

    state_t        state_q;
    logic [HW-1:0] hour_q;
    logic [HW-1:0] hour_d;
    logic          day_carry_q;
    logic          day_carry_d;
    logic          setting_q;
    logic [2:0]    btn_lvl;
    logic [2:0]    btn_prev_q;
    logic [2:0]    btn_ev;

    assign btn_lvl = {btn_ampm, btn_dec, btn_inc};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_edge
            assign btn_ev[gi] = btn_lvl[gi] & ~btn_prev_q[gi];
        end
    endgenerate

    // Only one edit per cycle: AM/PM beats increment, which beats decrement.
    always_comb begin
        hour_d      = hour_q;
        day_carry_d = 1'b0;
        if (state_q == ST_SET) begin
            if (btn_ev[B_AMPM]) begin
                hour_d = (hour_q >= H12) ? (hour_q - H12) : (hour_q + H12);
            end else if (btn_ev[B_INC]) begin
                if (mode) begin
                    if (hour_q == H11)      hour_d = H0;
                    else if (hour_q == H23) hour_d = H12;
                    else                    hour_d = hour_q + H1;
                end else begin
                    hour_d = (hour_q == H23) ? H0 : (hour_q + H1);
                end
            end else if (btn_ev[B_DEC]) begin
                if (mode) begin
                    if (hour_q == H0)       hour_d = H11;
                    else if (hour_q == H12) hour_d = H23;
                    else                    hour_d = hour_q - H1;
                end else begin
                    hour_d = (hour_q == H0) ? H23 : (hour_q - H1);
                end
            end
        end else if (carry_in) begin
            if (hour_q == H23) begin
                hour_d      = H0;
                day_carry_d = 1'b1;
            end else begin
                hour_d = hour_q + H1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            setting_q   <= 1'b0;
            hour_q      <= H0;
            day_carry_q <= 1'b0;
            btn_prev_q  <= 3'b000;
        end else begin
            state_q     <= set_en ? ST_SET : ST_RUN;
            setting_q   <= set_en;
            hour_q      <= hour_d;
            day_carry_q <= day_carry_d;
            btn_prev_q  <= btn_lvl;
        end
    end

    // 12h view maps midnight to 12 and folds afternoon hours down by 12.
    always_comb begin
        disp_hour = hour_q;
        if (mode) begin
            if (hour_q == H0)      disp_hour = H12;
            else if (hour_q > H12) disp_hour = hour_q - H12;
        end
    end

    assign hour24    = hour_q;
    assign pm        = (hour_q >= H12);
    assign day_carry = day_carry_q;
    assign setting   = setting_q;

endmodule

// File: tb/tb_hour_setter_12to24.sv
// Directed and random checks of hour_setter_12to24 against a modular-arithmetic
// model of the hour, its 12h view and the edit rules.
module tb_hour_setter_12to24;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       set_en = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic       btn_ampm = 1'b0;
    logic       carry_in = 1'b0;
    logic [6:0] hour24;
    logic [6:0] disp_hour;
    logic       pm;
    logic       day_carry;
    logic       setting;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    int m_hour = 0;
    int m_dc   = 0;
    int m_set  = 0;
    int m_pinc = 0;
    int m_pdec = 0;
    int m_pamp = 0;

    hour_setter_12to24 #(.HW(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .set_en    (set_en),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .btn_ampm  (btn_ampm),
        .carry_in  (carry_in),
        .hour24    (hour24),
        .disp_hour (disp_hour),
        .pm        (pm),
        .day_carry (day_carry),
        .setting   (setting)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_hour = 0; m_dc = 0; m_set = 0;
        m_pinc = 0; m_pdec = 0; m_pamp = 0;
    endtask

    // Apply the rules for one clock edge using the inputs currently driven.
    task automatic model_step();
        int ev_i, ev_d, ev_a, half;
        ev_i = (btn_inc  && !m_pinc) ? 1 : 0;
        ev_d = (btn_dec  && !m_pdec) ? 1 : 0;
        ev_a = (btn_ampm && !m_pamp) ? 1 : 0;
        half = (m_hour / 12) * 12;
        m_dc = 0;
        if (m_set != 0) begin
            if (ev_a != 0)      m_hour = (m_hour + 12) % 24;
            else if (ev_i != 0) m_hour = mode ? half + (m_hour % 12 + 1) % 12 : (m_hour + 1) % 24;
            else if (ev_d != 0) m_hour = mode ? half + (m_hour % 12 + 11) % 12 : (m_hour + 23) % 24;
        end else if (carry_in) begin
            m_dc   = (m_hour == 23) ? 1 : 0;
            m_hour = (m_hour + 1) % 24;
        end
        m_set  = set_en ? 1 : 0;
        m_pinc = btn_inc ? 1 : 0;
        m_pdec = btn_dec ? 1 : 0;
        m_pamp = btn_ampm ? 1 : 0;
    endtask

    task automatic check_all(input string tag);
        int exp_disp;
        exp_disp = mode ? ((m_hour + 11) % 12) + 1 : m_hour;
        chk({tag, ":hour24"},    int'(hour24),    m_hour);
        chk({tag, ":disp_hour"}, int'(disp_hour), exp_disp);
        chk({tag, ":pm"},        int'(pm),        (m_hour >= 12) ? 1 : 0);
        chk({tag, ":day_carry"}, int'(day_carry), m_dc);
        chk({tag, ":setting"},   int'(setting),   m_set);
        chk({tag, ":range"},     (hour24 < 7'd24) ? 1 : 0, 1);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic run_carries(input int n);
        for (int i = 0; i < n; i++) begin
            carry_in = 1'b1; tick("carry");
            carry_in = 1'b0; tick("carry_idle");
        end
    endtask

    task automatic press(input int which);
        case (which)
            0: btn_inc  = 1'b1;
            1: btn_dec  = 1'b1;
            default: btn_ampm = 1'b1;
        endcase
        tick("press");
        btn_inc = 1'b0; btn_dec = 1'b0; btn_ampm = 1'b0;
        tick("release");
    endtask

    initial begin
        // Power-up reset
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("por_hour24", int'(hour24), 0);
        chk("por_setting", int'(setting), 0);
        chk("por_day_carry", int'(day_carry), 0);
        rst_n = 1'b1;
        tick("post_por");

        // Async reset mid-edit with hour 15, button held through release
        run_carries(15);
        chk("at15", int'(hour24), 15);
        mode = 1'b1; set_en = 1'b1; tick("enter_set");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_hour24", int'(hour24), 0);
        chk("arst_disp", int'(disp_hour), 12);
        chk("arst_pm", int'(pm), 0);
        chk("arst_setting", int'(setting), 0);
        set_en = 1'b0; btn_inc = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) tick("held_inc");
        chk("held_inc_no_fire", int'(hour24), 0);
        btn_inc = 1'b0; tick("held_release");

        // RUN rollover 22 -> 23 -> 0 in 12h view
        run_carries(22);
        carry_in = 1'b1; tick("roll_23");
        chk("roll23_hour", int'(hour24), 23);
        chk("roll23_disp", int'(disp_hour), 11);
        chk("roll23_pm", int'(pm), 1);
        chk("roll23_dc", int'(day_carry), 0);
        carry_in = 1'b0; tick("roll_gap");
        carry_in = 1'b1; tick("roll_0");
        chk("roll0_hour", int'(hour24), 0);
        chk("roll0_dc", int'(day_carry), 1);
        chk("roll0_disp", int'(disp_hour), 12);
        chk("roll0_pm", int'(pm), 0);
        carry_in = 1'b0; tick("roll_after");
        chk("roll_dc_clear", int'(day_carry), 0);

        // 12h edit wrap within each half-day
        run_carries(11);
        set_en = 1'b1; tick("set12");
        press(0);
        chk("am_wrap_hour", int'(hour24), 0);
        chk("am_wrap_disp", int'(disp_hour), 12);
        press(2);
        press(1);
        chk("pm_at23", int'(hour24), 23);
        press(0);
        chk("pm_wrap_hour", int'(hour24), 12);
        chk("pm_wrap_pm", int'(pm), 1);
        press(1);
        chk("pm_dec_wrap", int'(hour24), 23);

        // AM/PM beats increment; a held level acts once
        set_en = 1'b0; tick("leave_set");
        run_carries(4);
        chk("at3", int'(hour24), 3);
        set_en = 1'b1; tick("set_prio");
        btn_ampm = 1'b1; btn_inc = 1'b1; tick("prio");
        chk("prio_hour", int'(hour24), 15);
        repeat (10) tick("held");
        chk("held_once", int'(hour24), 15);
        btn_ampm = 1'b0; btn_inc = 1'b0; tick("prio_release");

        // Carry discarded in SET, resumes from edited value in RUN
        mode = 1'b0;
        press(2);
        for (int i = 0; i < 4; i++) press(0);
        chk("at7", int'(hour24), 7);
        carry_in = 1'b1; tick("set_carry");
        chk("set_carry_hour", int'(hour24), 7);
        chk("set_carry_dc", int'(day_carry), 0);
        carry_in = 1'b0; tick("set_carry_gap");
        set_en = 1'b0; tick("exit_set");
        carry_in = 1'b1; tick("run_carry");
        chk("run_carry_hour", int'(hour24), 8);
        carry_in = 1'b0; tick("run_carry_gap");

        // 24h edit wrap
        set_en = 1'b1; tick("set24");
        for (int i = 0; i < 8; i++) press(1);
        chk("at0", int'(hour24), 0);
        btn_dec = 1'b1; tick("dec24");
        chk("dec24_hour", int'(hour24), 23);
        chk("dec24_disp", int'(disp_hour), 23);
        chk("dec24_pm", int'(pm), 1);
        btn_dec = 1'b0; tick("dec24_rel");
        btn_inc = 1'b1; tick("inc24");
        chk("inc24_hour", int'(hour24), 0);
        btn_inc = 1'b0; tick("inc24_rel");

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 19) == 0) set_en = ~set_en;
            btn_inc  = ($urandom_range(0, 2) == 0);
            btn_dec  = ($urandom_range(0, 2) == 0);
            btn_ampm = ($urandom_range(0, 3) == 0);
            carry_in = ($urandom_range(0, 2) == 0);
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hour_setter_12to24.md
Name: hour_setter_12to24

Overview:
- Owns the clock's hour register, which is always held in 24-hour form (0-23).
- Advances on minute rollover during normal running.
- Lets the user edit the hour with buttons while viewing 12-hour or 24-hour format, converting each 12h edit back into the 24h register.
- Drives the hour digits and the PM indicator of the display path.

Parameters:
- HW, 7, width of hour buses (matches the 7-bit hour buses used across the clock datapath)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  1 = 12-hour display/edit, 0 = 24-hour
- set_en  in  1  level; 1 = user is in hour-set mode
- btn_inc  in  1  synchronized, debounced level; rising edge = increment
- btn_dec  in  1  synchronized, debounced level; rising edge = decrement
- btn_ampm  in  1  synchronized, debounced level; rising edge = toggle AM/PM
- carry_in  in  1  one-cycle pulse from minute counter on 59->0
- hour24  out  HW  registered hour, 0-23
- disp_hour  out  HW  displayed hour: 12h form (1-12) if mode=1, else hour24
- pm  out  1  1 when hour24 >= 12 (valid in both modes)
- day_carry  out  1  registered one-cycle pulse on 23->0 rollover in RUN
- setting  out  1  1 while FSM is in SET

Behaviour:
- Reset (async, rst_n=0):
  - hour24=0, day_carry=0, FSM=RUN, setting=0.
  - All edge-detect history registers = 0, so a button held through reset does not fire on release of reset.
  - Reset mid-edit discards the edit.
- Edge detect:
  - Per button, prev register updated every clk.
  - Event = level & ~prev at the sampling edge.
  - The action takes effect in hour24 at that same edge (visible the cycle after the level rises).
- FSM states RUN and SET:
  - RUN->SET at the edge where set_en=1.
  - SET->RUN at the edge where set_en=0.
  - setting is registered and equals (state==SET).
- RUN:
  - carry_in=1 -> hour24 = (hour24==23) ? 0 : hour24+1.
  - day_carry=1 for exactly that cycle when hour24 goes 23->0; otherwise day_carry=0.
  - Button events are ignored, but prev registers still track.
- SET:
  - carry_in pulses are discarded; no pending count and no day_carry.
  - Priority per cycle: ampm > inc > dec. Only one action is applied; lower-priority events in the same cycle are dropped.
  - mode=0, inc: hour24 = (23 -> 0, else +1). dec: (0 -> 23, else -1).
  - mode=1, inc: cycles within the current half-day.
    - AM: 0->1->...->11->0.
    - PM: 12->13->...->23->12.
    - The displayed sequence is 12,1,...,11,12. pm is unchanged.
  - mode=1, dec: reverse of the mode=1 inc cycle (AM 0->11, PM 12->23).
  - ampm (either mode): hour24 = (hour24>=12) ? hour24-12 : hour24+12.
  - A mode change during SET takes effect on the next action; hour24 itself is unaffected.
  - The edit is committed continuously; leaving SET needs no extra commit cycle.
  - The first carry_in after returning to RUN increments from the edited value.
- Display (combinational from hour24 and mode):
  - mode=1: hour24=0 -> 12; hour24>12 -> hour24-12; else hour24.
  - mode=0: disp_hour = hour24.
  - pm = (hour24>=12).
  - Upper bits above 5 are always 0.
- Invariant: hour24 never leaves 0-23 under any input sequence.

Test Plan:
- Reset: rst_n low mid-cycle with hour24=15 -> hour24=0, disp_hour=12 (mode=1), pm=0, setting=0 immediately (async); btn_inc held high across reset release -> no increment.
- RUN rollover: hour24=22, two carry_in pulses -> 23 then 0; day_carry=1 only on the 23->0 cycle; mode=1 shows disp 11/pm=1, then 12/pm=0.
- 12h edit wrap: SET, mode=1, hour24=11 (11 AM), btn_inc edge -> hour24=0 (disp 12, pm=0); from hour24=23, inc -> 12 (disp 12, pm=1); from hour24=12, dec -> 23.
- AM/PM toggle and priority: hour24=3, btn_ampm and btn_inc rise in the same cycle -> hour24=15 only; held level over 10 cycles -> exactly one action.
- SET ignores carry: SET with hour24=7, carry_in pulse -> stays 7, no day_carry; exit SET, then carry_in -> 8.
- 24h edit: mode=0, SET, hour24=0, btn_dec edge -> 23, disp_hour=23, pm=1; btn_inc edge -> 0.
